// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter. Picks the highest-priority exception or interrupt for the
// instruction in MEM and drives the cp0_reg exception inputs combinationally. It also issues a
// one-cycle registered pipeline flush together with the redirect PC.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] EXC_NONE   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        int_pending_o
);

  localparam logic [4:0] RegStatus = 5'd12;
  localparam logic [4:0] RegCause  = 5'd13;
  localparam logic [4:0] RegEpc    = 5'd14;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] newpc_q, newpc_d;
  logic        int_pend_q, int_pend_d;

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_req, int_sel, take;

  // Only the bits that feed the interrupt decision are used from Status/Cause.
  logic unused_bits;
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  // WB-stage mtc0 bypass so an mtc0 one stage ahead is already visible here.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        RegStatus: eff_status = wb_cp0_data_i;
        RegCause:  eff_cause[9:8] = wb_cp0_data_i[9:8];  // only the software IP bits are writable
        RegEpc:    eff_epc = wb_cp0_data_i;
        default:   ;
      endcase
    end
  end

  assign int_req = eff_status[0] & ~eff_status[1] & (|(eff_cause[15:8] & eff_status[15:8]));
  assign int_sel = int_req | int_pend_q;
  // Flags are ignored while flushing, so a squashed instruction cannot raise a second exception.
  assign take    = inst_valid_i & ~stall_i & (state_q == StIdle);

  assign current_inst_addr_o = pc_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign flush_o             = (state_q == StFlush);
  assign newpc_o             = newpc_q;
  assign int_pending_o       = int_pend_q;

  // Priority encoder for the exception cause and faulting address.
  always_comb begin
    excepttype_o = EXC_NONE;
    bad_addr_o   = 32'h0;
    if (take) begin
      if (int_sel) begin
        excepttype_o = 32'h1;
      end else if (adel_if_i) begin
        excepttype_o = 32'h4;
        bad_addr_o   = pc_i;
      end else if (ri_i) begin
        excepttype_o = 32'ha;
      end else if (syscall_i) begin
        excepttype_o = 32'h8;
      end else if (break_i) begin
        excepttype_o = 32'h9;
      end else if (ov_i) begin
        excepttype_o = 32'hc;
      end else if (trap_i) begin
        excepttype_o = 32'hd;
      end else if (adel_ld_i) begin
        excepttype_o = 32'h4;
        bad_addr_o   = mem_addr_i;
      end else if (ades_st_i) begin
        excepttype_o = 32'h5;
        bad_addr_o   = mem_addr_i;
      end else if (eret_i) begin
        excepttype_o = 32'he;
      end
    end
  end

  // Next-state logic for the flush FSM, the redirect PC and the pending-interrupt latch.
  always_comb begin
    state_d    = state_q;
    newpc_d    = newpc_q;
    int_pend_d = int_pend_q;
    unique case (state_q)
      StIdle: begin
        if (take && (excepttype_o != EXC_NONE)) begin
          state_d = StFlush;
          newpc_d = (excepttype_o == 32'he) ? eff_epc : EXC_VECTOR;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (take && int_sel) begin
      int_pend_d = 1'b0;
    end else if (!int_req) begin
      int_pend_d = 1'b0;
    end else if (!inst_valid_i || stall_i) begin
      int_pend_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      newpc_q    <= 32'h0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      newpc_q    <= newpc_d;
      int_pend_q <= int_pend_d;
    end
  end

endmodule
